// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - VGA 640x480@60 timing constants and framebuffer geometry
package display_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int SCALE = 5;
  localparam int FB_W  = 128;
  localparam int FB_H  = 96;
  localparam int FB_XW = $clog2(FB_W);
  localparam int FB_YW = $clog2(FB_H);
  localparam int FB_AW = FB_YW + FB_XW - 3;
  localparam int SUB_W = $clog2(SCALE);
  localparam int CNT_W = 10;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } video_ctl_t;

  localparam video_ctl_t CTL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - h/v raster counters with sync, active and frame-start decode
module vga_timing
  import display_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output video_ctl_t ctl_o,
  output logic       h_active_o,
  output logic       v_active_o,
  output logic       line_end_o,
  output logic       frame_end_o
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(P_H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(P_H_ACTIVE + P_H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(P_V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(P_V_ACTIVE + P_V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_wrap, v_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    h_active_o   = (h_cnt_q < H_ACT);
    v_active_o   = (v_cnt_q < V_ACT);
    line_end_o   = h_wrap;
    frame_end_o  = h_wrap && v_wrap;
    ctl_o.active = h_active_o && v_active_o;
    ctl_o.hs     = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    ctl_o.vs     = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    ctl_o.fs     = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 5x upscaled 128x96 monochrome scanout onto 640x480 VGA
module vga_scanout
  import display_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic             CLK_VGA,
  input  logic             RST,
  output logic [FB_AW-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             VGA_pixel,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SCALE - 1);
  localparam logic [FB_YW-1:0] FB_Y_LAST = FB_YW'(FB_H - 1);

  video_ctl_t       ctl0, ctl1_q;
  logic             h_active, v_active, line_end, frame_end;
  logic [SUB_W-1:0] hx_sub_q, hx_sub_d, vy_sub_q, vy_sub_d;
  logic [FB_XW-1:0] fb_x_q, fb_x_d;
  logic [FB_YW-1:0] fb_y_q, fb_y_d;
  logic [2:0]       bit_idx1_q;
  logic             pix_q, pix_d, hs_q, vs_q, fs_q;

  vga_timing #(
    .P_H_ACTIVE (P_H_ACTIVE),
    .P_H_FP     (P_H_FP),
    .P_H_SYNC   (P_H_SYNC),
    .P_H_BP     (P_H_BP),
    .P_V_ACTIVE (P_V_ACTIVE),
    .P_V_FP     (P_V_FP),
    .P_V_SYNC   (P_V_SYNC),
    .P_V_BP     (P_V_BP)
  ) u_timing (
    .clk_i       (CLK_VGA),
    .rst_i       (RST),
    .ctl_o       (ctl0),
    .h_active_o  (h_active),
    .v_active_o  (v_active),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  always_comb begin
    hx_sub_d = hx_sub_q;
    fb_x_d   = fb_x_q;
    if (line_end) begin
      hx_sub_d = '0;
      fb_x_d   = '0;
    end else if (h_active) begin
      if (hx_sub_q == SUB_LAST) begin
        hx_sub_d = '0;
        fb_x_d   = fb_x_q + 1'b1;
      end else begin
        hx_sub_d = hx_sub_q + 1'b1;
      end
    end
  end

  // fb_y wraps to 0 after the last row so rd_addr never exceeds the 1536-byte memory
  always_comb begin
    vy_sub_d = vy_sub_q;
    fb_y_d   = fb_y_q;
    if (frame_end) begin
      vy_sub_d = '0;
      fb_y_d   = '0;
    end else if (line_end && v_active) begin
      if (vy_sub_q == SUB_LAST) begin
        vy_sub_d = '0;
        fb_y_d   = (fb_y_q == FB_Y_LAST) ? '0 : fb_y_q + 1'b1;
      end else begin
        vy_sub_d = vy_sub_q + 1'b1;
      end
    end
  end

  assign rd_addr = {fb_y_q, fb_x_q[FB_XW-1:3]};
  assign pix_d   = ctl1_q.active & rd_data[3'd7 - bit_idx1_q];

  always_ff @(posedge CLK_VGA) begin
    if (RST) begin
      hx_sub_q   <= '0;
      vy_sub_q   <= '0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      bit_idx1_q <= '0;
      ctl1_q     <= CTL_IDLE;
      pix_q      <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      hx_sub_q   <= hx_sub_d;
      vy_sub_q   <= vy_sub_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      bit_idx1_q <= fb_x_q[2:0];
      ctl1_q     <= ctl0;
      pix_q      <= pix_d;
      hs_q       <= ctl1_q.hs;
      vs_q       <= ctl1_q.vs;
      fs_q       <= ctl1_q.fs;
    end
  end

  assign VGA_pixel   = pix_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench: full-size scanout plus a narrow-line instance for frame timing
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        rst, rst_s;
  logic [10:0] rd_addr, rd_addr_s;
  logic [7:0]  rd_data, rd_data_s;
  logic        pix, hs, vs, fs;
  logic        pix_s, hs_s, vs_s, fs_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int mode_s = 0;

  always #20 clk = ~clk;

  vga_scanout u_dut (
    .CLK_VGA     (clk),
    .RST         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .VGA_pixel   (pix),
    .hsync       (hs),
    .vsync       (vs),
    .frame_start (fs)
  );

  // 20-clock lines (10 active), full 525-line frame: 10500 clocks per frame
  vga_scanout #(
    .P_H_ACTIVE (10),
    .P_H_FP     (2),
    .P_H_SYNC   (4),
    .P_H_BP     (4)
  ) u_small (
    .CLK_VGA     (clk),
    .RST         (rst_s),
    .rd_addr     (rd_addr_s),
    .rd_data     (rd_data_s),
    .VGA_pixel   (pix_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .frame_start (fs_s)
  );

  function automatic logic [7:0] mem_byte(input int m, input logic [10:0] a);
    case (m)
      1:       return (a == 11'd0) ? 8'h80 : 8'h00;
      2:       return 8'hFF;
      3:       return a[7:0];
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    rd_data   <= mem_byte(mode, rd_addr);
    rd_data_s <= mem_byte(mode_s, rd_addr_s);
  end

  typedef struct {
    int   mode;
    int   h;
    int   v;
    int   addr;
    logic pix;
    logic hs;
    logic vs;
    logic fs;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic reset_main(input bit chk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (chk) begin
      check("rst_addr", rd_addr, 0);
      check("rst_pix", pix, 0);
      check("rst_hsync", hs, 1);
      check("rst_vsync", vs, 1);
      check("rst_fs", fs, 0);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int first_fall, second_fall, low_len, bad, fs_cnt, fs_at, n;
    int in_cnt, out_cnt, ones0, ones1;
    int fs_times[3];
    logic prev;

    rst   = 1'b1;
    rst_s = 1'b1;

    //          mode h    v   addr pix hs  vs  fs
    vecs[0]  = '{1,   0,   0,  0,  1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1,   4,   0,  0,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1,   8,   0,  0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1, 640,   0,  0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1, 700,   0,  0,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1, 752,   0,  0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1,   2,   4,  0,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1,   2,   5, 16,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3,  40,   5, 17,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{3,  70,   5, 17,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{3,  75,   5, 17,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3, 600,  10, 47,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{3, 605,  10, 47,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{3, 620,  10, 47,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{3, 635,  10, 47,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{3, 639,  11, 47,  1'b1, 1'b1, 1'b1, 1'b0};

    // line timing with blank memory
    mode = 0;
    reset_main(1'b1);
    check("t0_addr", rd_addr, 0);
    check("t0_pix", pix, 0);
    check("t0_fs", fs, 0);
    first_fall = -1; second_fall = -1; low_len = 0; bad = 0;
    fs_cnt = 0; fs_at = -1; prev = 1'b1;
    while (cyc < 1700) begin
      if (prev === 1'b1 && hs === 1'b0) begin
        if (first_fall < 0) first_fall = cyc;
        else if (second_fall < 0) second_fall = cyc;
      end
      if (hs === 1'b0 && second_fall < 0) low_len++;
      if (vs !== 1'b1 || pix !== 1'b0) bad++;
      if (fs === 1'b1) begin
        fs_cnt++;
        if (fs_at < 0) fs_at = cyc;
      end
      prev = hs;
      step();
    end
    check("hsync_first_low", first_fall, 658);
    check("hsync_low_len", low_len, 96);
    check("hsync_second_low", second_fall, 1458);
    check("blank_line_bad", bad, 0);
    check("fs_count_lines", fs_cnt, 1);
    check("fs_first_at", fs_at, 2);

    reset_main(1'b0);
    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].mode;
      n = vecs[i].v * 800 + vecs[i].h;
      wait_cyc(n);
      check($sformatf("vec%0d_addr", i), rd_addr, vecs[i].addr);
      wait_cyc(n + 2);
      check($sformatf("vec%0d_pix", i), pix, vecs[i].pix);
      check($sformatf("vec%0d_hsync", i), hs, vecs[i].hs);
      check($sformatf("vec%0d_vsync", i), vs, vecs[i].vs);
      check($sformatf("vec%0d_fs", i), fs, vecs[i].fs);
    end

    // all-ones memory, then a one-clock reset at h=300 v=3
    mode = 2;
    reset_main(1'b0);
    for (int l = 0; l < 3; l++) begin
      in_cnt = 0; out_cnt = 0;
      for (int o = 0; o < 800; o++) begin
        wait_cyc(l * 800 + o + 2);
        if (pix === 1'b1) begin
          if (o < 640) in_cnt++;
          else out_cnt++;
        end
      end
      check($sformatf("ff_line%0d_on", l), in_cnt, 640);
      check($sformatf("ff_line%0d_blank", l), out_cnt, 0);
    end
    wait_cyc(2700);
    check("pre_rst_pix", pix, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    check("mid_rst0_addr", rd_addr, 0);
    check("mid_rst0_pix", pix, 0);
    check("mid_rst0_hsync", hs, 1);
    check("mid_rst0_vsync", vs, 1);
    check("mid_rst0_fs", fs, 0);
    step();
    check("mid_rst1_pix", pix, 0);
    check("mid_rst1_fs", fs, 0);
    step();
    check("mid_rst2_pix", pix, 1);
    check("mid_rst2_fs", fs, 1);
    check("mid_rst2_hsync", hs, 1);
    step();
    check("mid_rst3_fs", fs, 0);
    first_fall = -1; prev = hs;
    while (cyc < 1000 && first_fall < 0) begin
      if (prev === 1'b1 && hs === 1'b0) first_fall = cyc;
      prev = hs;
      step();
    end
    check("mid_rst_hsync_low", first_fall, 658);

    // frame-level timing on the narrow-line instance
    mode_s = 1;
    @(negedge clk);
    rst_s = 1'b0;
    cyc = 0;
    first_fall = -1; second_fall = -1; low_len = 0; bad = 0;
    fs_cnt = 0; ones0 = 0; ones1 = 0; prev = 1'b1;
    for (int k = 0; k < 3; k++) fs_times[k] = -1;
    while (cyc < 21010) begin
      n = cyc - 2;
      if (cyc == 9589) check("small_addr_row95", rd_addr_s, 1520);
      if (cyc == 10000) mode_s = 2;
      if (fs_s === 1'b1) begin
        if (fs_cnt < 3) fs_times[fs_cnt] = cyc;
        fs_cnt++;
      end
      if (prev === 1'b1 && vs_s === 1'b0) begin
        if (first_fall < 0) first_fall = cyc;
        else if (second_fall < 0) second_fall = cyc;
      end
      if (vs_s === 1'b0 && second_fall < 0) low_len++;
      prev = vs_s;
      if (pix_s === 1'b1 && n >= 0) begin
        if (n < 10500) ones0++;
        else if (n < 21000) ones1++;
        if (((n % 10500) / 20) >= 480) bad++;
      end
      step();
    end
    check("small_fs_count", fs_cnt, 3);
    check("small_fs0", fs_times[0], 2);
    check("small_fs1", fs_times[1], 10502);
    check("small_fs2", fs_times[2], 21002);
    check("small_vsync_first_low", first_fall, 9802);
    check("small_vsync_low_len", low_len, 40);
    check("small_vsync_second_low", second_fall, 20302);
    check("small_frame0_px", ones0, 25);
    check("small_frame1_px", ones1, 4800);
    check("small_vblank_px", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
